mem_wb_reg: RTL
===============

# mem_wb_reg

MEM/WB pipeline register for the five-stage pipelined CPU. It sits directly downstream of the EX/MEM register and upstream of the register file write port. It resolves the destination register and write-back data. It also buffers a data-cache load that completes while the pipeline is stalled, because EX/MEM drops its data read/write request on `dhit`.

## Interface
Parameters:
- none (widths come from `cpu_types_pkg`; `word_t` is 32 b, `regbits_t` is 5 b)

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system clock, rising edge
- `nRST`  in  1  asynchronous active-low reset
- `enable_MEM_WB`  in  1  advance stage (from hazard unit)
- `flush_MEM_WB`  in  1  insert bubble
- `dhit`  in  1  data cache hit/complete
- `dmemload`  in  32  data cache read data, valid when `dhit`
- `dmemREN_EX_MEM`, `dmemWEN_EX_MEM`  in  1 each  pending data read/write request
- `WEN_EX_MEM`  in  1  register write enable
- `reg_dest_EX_MEM`  in  `reg_dest_mux_selection`  SEL_RD / SEL_RT / SEL_31
- `Rt_EX_MEM`, `Rd_EX_MEM`  in  5 each  candidate destination registers
- `mem_to_reg_EX_MEM`  in  `mem_to_reg_mux_selection`  SEL_RESULT / SEL_DLOAD / SEL_NPC
- `result_EX_MEM`  in  32  ALU result
- `next_imemaddr_EX_MEM`  in  32  PC+4 (link value)
- `halt_EX_MEM`  in  1  halt instruction
- `imemaddr_EX_MEM`, `instruction_EX_MEM`  in  32 each  tracker fields
- `WEN_MEM_WB`  out  1  register file write enable
- `wsel_MEM_WB`  out  5  destination register
- `wdat_MEM_WB`  out  32  write-back data
- `halt_MEM_WB`  out  1  halt reached WB (sticky)
- `mem_stall`  out  1  combinational; data access outstanding
- `imemaddr_MEM_WB`, `instruction_MEM_WB`  out  32 each  tracker fields

## Operation
- **Destination register:** `wsel` is Rd for SEL_RD, Rt for SEL_RT, and 5'd31 for SEL_31.
- **Write data:** `wdat` is `result` for SEL_RESULT and `next_imemaddr` for SEL_NPC. For SEL_DLOAD it is `dmemload`, or `load_buf` when in HOLD.
- **mem_stall:** equals `(dmemREN_EX_MEM | dmemWEN_EX_MEM) & ~dhit & (state == IDLE)`.
- **FSM states:** IDLE, HOLD.
  - IDLE, `dhit` & `dmemREN_EX_MEM` & ~`enable_MEM_WB` & ~`flush_MEM_WB`: `load_buf <= dmemload`, go to HOLD.
  - IDLE, `enable_MEM_WB`: latch all fields, stay IDLE.
  - HOLD, `enable_MEM_WB` & ~`flush_MEM_WB`: latch all fields using `load_buf` as load data, go to IDLE.
  - HOLD, otherwise: hold.
  - `flush_MEM_WB` in any state: go to IDLE and clear `load_buf`.
- **Store completion:** `dhit` with `dmemWEN_EX_MEM` while stalled needs no buffer and stays IDLE. `mem_stall` deasserts because `dhit` is high, and EX/MEM then clears its request.
- **Flush:** a flush writes a bubble: WEN=0, wsel=0, wdat=0, halt unchanged, tracker fields 0. Flush has priority over enable.
- **Halt:** `halt_MEM_WB` is set when a latched halt is 1 and stays set until reset; flush does not clear it.
- **Tracker fields:** latched alongside the data on every enabled, unflushed cycle.

## Timing
- **Reset:** all outputs 0, state IDLE, `load_buf` 0. `mem_stall` is combinational from inputs and state.
- **Latency:** one cycle. Inputs present on the edge with enable=1 appear on the outputs after that edge.
- With enable=0 and no flush, outputs hold their values indefinitely.
- `dhit` and enable in the same cycle (IDLE): `dmemload` is written straight into `wdat`, with no HOLD.
- HOLD persists across any number of stall cycles. A second `dhit` while in HOLD is ignored.
- Reset asserted mid-HOLD discards the buffered load immediately (asynchronous).

## Configuration
- **`MEM_WB_TRACKER_EN` defined:** `imemaddr_MEM_WB` and `instruction_MEM_WB` are registered as described above.
- **Undefined:** the tracker registers are not built and both outputs are tied to 32'd0. All other behaviour is identical.

## Test plan
- **Reset:** assert `nRST`=0 mid-run → all outputs 0, `mem_stall`=0, state IDLE.
- **ALU write-back:** R-type with SEL_RD, Rd=5'd9, result=32'h0000_00AA, enable=1 → next cycle WEN=1, wsel=9, wdat=32'h0000_00AA.
- **Load under stall:** dREN=1, dhit=0 → `mem_stall`=1. Then dhit=1 with dmemload=32'hDEAD_BEEF while enable=0 → HOLD, `mem_stall`=0. Deassert dREN and hold enable=0 for 3 cycles, then enable=1 → wdat=32'hDEAD_BEEF, wsel=Rt.
- **JAL link:** SEL_31 with SEL_NPC, next_imemaddr=32'h0000_0104 → wsel=31, wdat=32'h0000_0104.
- **Flush priority:** flush=1 and enable=1 together while in HOLD → WEN=0, wdat=0, state IDLE; a following enable does not reproduce the buffered data.
- **Halt:** halt_EX_MEM=1 latched, then a flush → `halt_MEM_WB` stays 1 until `nRST`=0.

Source files
------------

// File: rtl/mem_wb_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wb_reg : MEM/WB pipeline register; resolves write-back destination     |
// |              and data, and buffers a load that completes during a stall.   |
// |              Optional tracker registers enabled by MEM_WB_TRACKER_EN.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+

package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    SEL_RD = 2'd0,
    SEL_RT = 2'd1,
    SEL_31 = 2'd2
  } reg_dest_mux_selection;

  typedef enum logic [1:0] {
    SEL_RESULT = 2'd0,
    SEL_DLOAD  = 2'd1,
    SEL_NPC    = 2'd2
  } mem_to_reg_mux_selection;
endpackage

module mem_wb_reg
  import cpu_types_pkg::*;
(
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    enable_MEM_WB,
  input  logic                    flush_MEM_WB,
  input  logic                    dhit,
  input  word_t                   dmemload,
  input  logic                    dmemREN_EX_MEM,
  input  logic                    dmemWEN_EX_MEM,
  input  logic                    WEN_EX_MEM,
  input  reg_dest_mux_selection   reg_dest_EX_MEM,
  input  regbits_t                Rt_EX_MEM,
  input  regbits_t                Rd_EX_MEM,
  input  mem_to_reg_mux_selection mem_to_reg_EX_MEM,
  input  word_t                   result_EX_MEM,
  input  word_t                   next_imemaddr_EX_MEM,
  input  logic                    halt_EX_MEM,
  input  word_t                   imemaddr_EX_MEM,
  input  word_t                   instruction_EX_MEM,
  output logic                    WEN_MEM_WB,
  output regbits_t                wsel_MEM_WB,
  output word_t                   wdat_MEM_WB,
  output logic                    halt_MEM_WB,
  output logic                    mem_stall,
  output word_t                   imemaddr_MEM_WB,
  output word_t                   instruction_MEM_WB
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  word_t      r_load_buf;
  word_t      w_load_data;
  regbits_t   w_wsel;
  word_t      w_wdat;
  logic       w_capture;
  logic       w_latch;

  // A load finishing while the stage is frozen must be kept, because EX/MEM
  // drops its request as soon as dhit is seen.
  assign w_capture = (r_state == IDLE) & dhit & dmemREN_EX_MEM &
                     ~enable_MEM_WB & ~flush_MEM_WB;
  assign w_latch   = enable_MEM_WB & ~flush_MEM_WB;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush_MEM_WB) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_capture) w_state_next = HOLD;
        HOLD:    if (enable_MEM_WB) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_stall   = (dmemREN_EX_MEM | dmemWEN_EX_MEM) & ~dhit & (r_state == IDLE);
    w_load_data = (r_state == HOLD) ? r_load_buf : dmemload;
  end

  always_comb begin
    w_wsel = Rd_EX_MEM;
    case (reg_dest_EX_MEM)
      SEL_RD:  w_wsel = Rd_EX_MEM;
      SEL_RT:  w_wsel = Rt_EX_MEM;
      SEL_31:  w_wsel = 5'd31;
      default: w_wsel = Rd_EX_MEM;
    endcase
  end

  always_comb begin
    w_wdat = result_EX_MEM;
    case (mem_to_reg_EX_MEM)
      SEL_RESULT: w_wdat = result_EX_MEM;
      SEL_DLOAD:  w_wdat = w_load_data;
      SEL_NPC:    w_wdat = next_imemaddr_EX_MEM;
      default:    w_wdat = result_EX_MEM;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_load_buf <= '0;
    end else if (flush_MEM_WB) begin
      r_load_buf <= '0;
    end else if (w_capture) begin
      r_load_buf <= dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      WEN_MEM_WB  <= 1'b0;
      wsel_MEM_WB <= '0;
      wdat_MEM_WB <= '0;
    end else if (flush_MEM_WB) begin
      WEN_MEM_WB  <= 1'b0;
      wsel_MEM_WB <= '0;
      wdat_MEM_WB <= '0;
    end else if (enable_MEM_WB) begin
      WEN_MEM_WB  <= WEN_EX_MEM;
      wsel_MEM_WB <= w_wsel;
      wdat_MEM_WB <= w_wdat;
    end
  end

  // Halt is sticky: only reset clears it, a bubble never does.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_MEM_WB <= 1'b0;
    end else if (w_latch && halt_EX_MEM) begin
      halt_MEM_WB <= 1'b1;
    end
  end

`ifdef MEM_WB_TRACKER_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      imemaddr_MEM_WB    <= '0;
      instruction_MEM_WB <= '0;
    end else if (flush_MEM_WB) begin
      imemaddr_MEM_WB    <= '0;
      instruction_MEM_WB <= '0;
    end else if (enable_MEM_WB) begin
      imemaddr_MEM_WB    <= imemaddr_EX_MEM;
      instruction_MEM_WB <= instruction_EX_MEM;
    end
  end
`else
  logic w_unused_trk;
  assign w_unused_trk       = ^{imemaddr_EX_MEM, instruction_EX_MEM};
  assign imemaddr_MEM_WB    = '0;
  assign instruction_MEM_WB = '0;
`endif

endmodule

`default_nettype wire
